// File: rtl/bilinear_window_gen_pkg.sv
// Shared definitions for the bilinear 2x2 window generator.
package bilinear_window_gen_pkg;

  // Default pixel width (RGB888).
  localparam int unsigned DW_DEF = 24;

  // Width of the column/row counters and the emitted coordinates.
  localparam int unsigned CW = 11;

  // Frame-tracking states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/bilinear_window_gen_line_ram.sv
// Single-line buffer: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module bilinear_window_gen_line_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned DW    = 24,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/bilinear_window_gen.sv
// Builds a 2x2 pixel neighbourhood plus its top-left coordinate for every
// interior position of the incoming frame, using one line of history.
module bilinear_window_gen
  import bilinear_window_gen_pkg::*;
#(
  parameter int unsigned H_PIX_MAX = 640,
  parameter int unsigned V_PIX_MAX = 480,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic          biliner_clk_in,
  input  logic          sys_rst,
  input  logic [DW-1:0] pix_data_i,
  input  logic          pix_valid_i,
  input  logic          frame_active_i,
  output logic          win_valid_o,
  output logic [DW-1:0] win_p00_o,
  output logic [DW-1:0] win_p01_o,
  output logic [DW-1:0] win_p10_o,
  output logic [DW-1:0] win_p11_o,
  output logic [CW-1:0] win_x_o,
  output logic [CW-1:0] win_y_o,
  output logic          win_eol_o,
  output logic          win_eof_o,
  output logic          line_err_o
);

  localparam logic [CW-1:0] H_LAST = CW'(H_PIX_MAX - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_PIX_MAX - 1);
  localparam int unsigned   RAW    = (H_PIX_MAX > 1) ? $clog2(H_PIX_MAX) : 1;

  // Frame tracking
  state_e        state_q;
  logic          fa_q;
  logic          line_err_q;
  logic [CW-1:0] in_col_q;
  logic [CW-1:0] in_row_q;

  logic          fa_rise;
  logic          fa_fall;
  logic          accept;
  logic          col_wrap;
  logic [CW-1:0] col_nxt;
  logic [CW-1:0] row_nxt;
  logic [CW-1:0] col_after;

  // Stage 1: pixel accepted, line RAM read in flight
  logic          s1_valid_q;
  logic [CW-1:0] s1_col_q;
  logic [CW-1:0] s1_row_q;
  logic [DW-1:0] s1_pix_q;
  logic [DW-1:0] ram_rdata;

  // Stage 2: previous column of both rows and the registered window
  logic [DW-1:0] prev_top_q;
  logic [DW-1:0] prev_bot_q;
  logic          emit;
  logic          win_valid_q;
  logic          win_eol_q;
  logic          win_eof_q;
  logic [DW-1:0] win_p00_q;
  logic [DW-1:0] win_p01_q;
  logic [DW-1:0] win_p10_q;
  logic [DW-1:0] win_p11_q;
  logic [CW-1:0] win_x_q;
  logic [CW-1:0] win_y_q;

  // Edge detection and next-position arithmetic for the input counters.
  always_comb begin
    fa_rise   = frame_active_i & ~fa_q;
    fa_fall   = ~frame_active_i & fa_q;
    accept    = (state_q == ACTIVE) & pix_valid_i;
    col_wrap  = (in_col_q == H_LAST);
    col_nxt   = col_wrap ? '0 : in_col_q + CW'(1);
    row_nxt   = col_wrap ? in_row_q + CW'(1) : in_row_q;
    // A pixel coincident with the falling edge is counted before the
    // partial-line test, so a row completed on that cycle is not an error.
    col_after = accept ? col_nxt : in_col_q;
  end

  // Frame FSM with input counters and the registered error pulse.
  always_ff @(posedge biliner_clk_in) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      fa_q       <= 1'b0;
      line_err_q <= 1'b0;
      in_col_q   <= '0;
      in_row_q   <= '0;
    end else begin
      fa_q       <= frame_active_i;
      line_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pix_valid_i) begin
            line_err_q <= 1'b1;
          end
          if (fa_rise) begin
            state_q  <= ACTIVE;
            in_col_q <= '0;
            in_row_q <= '0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            in_col_q <= col_nxt;
            in_row_q <= row_nxt;
          end
          if (fa_fall) begin
            state_q <= IDLE;
            if (col_after != '0) begin
              line_err_q <= 1'b1;
            end
          end else if (accept && col_wrap && (in_row_q == V_LAST)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!frame_active_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bilinear_window_gen_line_ram #(
    .DEPTH (H_PIX_MAX),
    .DW    (DW),
    .AW    (RAW)
  ) u_line_ram (
    .clk_i   (biliner_clk_in),
    .we_i    (accept),
    .waddr_i (in_col_q[RAW-1:0]),
    .wdata_i (pix_data_i),
    .re_i    (accept),
    .raddr_i (in_col_q[RAW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Stage 1: hold the accepted pixel and its position while the RAM reads.
  always_ff @(posedge biliner_clk_in) begin
    if (sys_rst) begin
      s1_valid_q <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_pix_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_col_q <= in_col_q;
        s1_row_q <= in_row_q;
        s1_pix_q <= pix_data_i;
      end
    end
  end

  // Windows exist only below the first row and right of the first column.
  always_comb begin
    emit = s1_valid_q && (s1_row_q != '0) && (s1_col_q != '0);
  end

  // Stage 2: shift the column history and register the assembled window.
  always_ff @(posedge biliner_clk_in) begin
    if (sys_rst) begin
      prev_top_q  <= '0;
      prev_bot_q  <= '0;
      win_valid_q <= 1'b0;
      win_eol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
      win_p00_q   <= '0;
      win_p01_q   <= '0;
      win_p10_q   <= '0;
      win_p11_q   <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      win_valid_q <= emit;
      win_eol_q   <= emit && (s1_col_q == H_LAST);
      win_eof_q   <= emit && (s1_col_q == H_LAST) && (s1_row_q == V_LAST);
      if (s1_valid_q) begin
        prev_top_q <= ram_rdata;
        prev_bot_q <= s1_pix_q;
      end
      if (emit) begin
        win_p00_q <= prev_top_q;
        win_p01_q <= ram_rdata;
        win_p10_q <= prev_bot_q;
        win_p11_q <= s1_pix_q;
        win_x_q   <= s1_col_q - CW'(1);
        win_y_q   <= s1_row_q - CW'(1);
      end
    end
  end

  assign win_valid_o = win_valid_q;
  assign win_eol_o   = win_eol_q;
  assign win_eof_o   = win_eof_q;
  assign win_p00_o   = win_p00_q;
  assign win_p01_o   = win_p01_q;
  assign win_p10_o   = win_p10_q;
  assign win_p11_o   = win_p11_q;
  assign win_x_o     = win_x_q;
  assign win_y_o     = win_y_q;
  assign line_err_o  = line_err_q;

endmodule

// File: tb/tb_bilinear_window_gen.sv
// Self-checking bench for bilinear_window_gen on a 4x3 frame.
module tb_bilinear_window_gen;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fa  = 1'b0;
  logic          pv  = 1'b0;
  logic [DW-1:0] pd  = '0;

  logic          win_valid_o, win_eol_o, win_eof_o, line_err_o;
  logic [DW-1:0] win_p00_o, win_p01_o, win_p10_o, win_p11_o;
  logic [10:0]   win_x_o, win_y_o;

  bilinear_window_gen #(
    .H_PIX_MAX (H),
    .V_PIX_MAX (V),
    .DW        (DW)
  ) dut (
    .biliner_clk_in (clk),
    .sys_rst        (rst),
    .pix_data_i     (pd),
    .pix_valid_i    (pv),
    .frame_active_i (fa),
    .win_valid_o    (win_valid_o),
    .win_p00_o      (win_p00_o),
    .win_p01_o      (win_p01_o),
    .win_p10_o      (win_p10_o),
    .win_p11_o      (win_p11_o),
    .win_x_o        (win_x_o),
    .win_y_o        (win_y_o),
    .win_eol_o      (win_eol_o),
    .win_eof_o      (win_eof_o),
    .line_err_o     (line_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] p00, p01, p10, p11;
    int          x, y;
    bit          eol, eof;
  } win_t;

  win_t exp_q[$];
  win_t obs_q[$];
  int   err_q[$];
  win_t e_w;
  win_t o_w;

  int cyc      = 0;
  bit rst_seen = 1'b1;
  int n_pass   = 0;
  int n_total  = 0;
  int err_seen = 0;

  // Image model: what has been written for the current frame
  logic [23:0] img [V][H];
  bit          open_f = 1'b0;
  int          m_row  = 0;
  int          m_col  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("rst_flags", {28'd0, win_valid_o, win_eol_o, win_eof_o, line_err_o}, 32'd0);
      check("rst_p00", {8'd0, win_p00_o}, 32'd0);
      check("rst_p01", {8'd0, win_p01_o}, 32'd0);
      check("rst_p10", {8'd0, win_p10_o}, 32'd0);
      check("rst_p11", {8'd0, win_p11_o}, 32'd0);
      check("rst_xy", {10'd0, win_x_o, win_y_o}, 32'd0);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e_w = exp_q.pop_front();
        check("win_valid", {31'd0, win_valid_o}, 32'd1);
        check("win_p00", {8'd0, win_p00_o}, {8'd0, e_w.p00});
        check("win_p01", {8'd0, win_p01_o}, {8'd0, e_w.p01});
        check("win_p10", {8'd0, win_p10_o}, {8'd0, e_w.p10});
        check("win_p11", {8'd0, win_p11_o}, {8'd0, e_w.p11});
        check("win_x", {21'd0, win_x_o}, 32'(e_w.x));
        check("win_y", {21'd0, win_y_o}, 32'(e_w.y));
        check("win_eol", {31'd0, win_eol_o}, {31'd0, e_w.eol});
        check("win_eof", {31'd0, win_eof_o}, {31'd0, e_w.eof});
      end else begin
        check("win_valid_idle", {29'd0, win_valid_o, win_eol_o, win_eof_o}, 32'd0);
      end
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
        check("line_err", {31'd0, line_err_o}, 32'd1);
      end else begin
        check("line_err_idle", {31'd0, line_err_o}, 32'd0);
      end
    end
    if (win_valid_o) begin
      o_w = '{cyc, win_p00_o, win_p01_o, win_p10_o, win_p11_o,
              int'(win_x_o), int'(win_y_o), win_eol_o, win_eof_o};
      obs_q.push_back(o_w);
    end
    if (line_err_o) err_seen++;
  end

  // Model of one driven pixel: store it and, where a full 2x2 exists, expect a window.
  function automatic void model_pix(logic [23:0] d);
    win_t w;
    if (!open_f) begin
      err_q.push_back(cyc + 1);
    end else if (m_row < V) begin
      img[m_row][m_col] = d;
      if (m_row >= 1 && m_col >= 1) begin
        w = '{cyc + 2, img[m_row-1][m_col-1], img[m_row-1][m_col],
              img[m_row][m_col-1], d, m_col - 1, m_row - 1,
              m_col == H - 1, (m_col == H - 1) && (m_row == V - 1)};
        exp_q.push_back(w);
      end
      m_col++;
      if (m_col == H) begin
        m_col = 0;
        m_row++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_pix(input logic [23:0] d);
    pv = 1'b1;
    pd = d;
    model_pix(d);
    tick();
    pv = 1'b0;
  endtask

  task automatic frame_start();
    fa     = 1'b1;
    open_f = 1'b1;
    m_row  = 0;
    m_col  = 0;
    idle(2);
  endtask

  task automatic frame_end(input bit with_pix, input logic [23:0] d);
    fa = 1'b0;
    if (with_pix) begin
      pv = 1'b1;
      pd = d;
      model_pix(d);
    end
    if (open_f && m_row < V && m_col != 0) err_q.push_back(cyc + 1);
    open_f = 1'b0;
    tick();
    pv = 1'b0;
    idle(3);
  endtask

  function automatic logic [23:0] pat(logic [23:0] tag, int r, int c);
    return tag + 24'(16 * r + c);
  endfunction

  task automatic send_lines(input int nrows, input logic [23:0] tag,
                            input bit gaps, input bit rnd);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < H; c++) begin
        drive_pix(rnd ? 24'($urandom) : pat(tag, r, c));
        if (gaps) idle(int'($urandom_range(0, 2)));
      end
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    fa     = 1'b0;
    pv     = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    while (err_q.size() > 0 && err_q[$] > cyc) void'(err_q.pop_back());
    open_f = 1'b0;
    m_row  = 0;
    m_col  = 0;
    idle(3);
    rst = 1'b0;
    tick();
    obs_q.delete();
    err_seen = 0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    err_seen = 0;
  endtask

  int n_y2;
  int n_eol;

  initial begin
    idle(3);
    rst = 1'b0;
    tick();

    // Plain 4x3 frame, pixel = 16*row + col
    clear_obs();
    frame_start();
    send_lines(V, 24'h0, 1'b0, 1'b0);
    frame_end(1'b0, '0);
    check("f1_count", 32'(obs_q.size()), 32'd6);
    if (obs_q.size() == 6) begin
      check("f1_first_p00", {8'd0, obs_q[0].p00}, 32'h00);
      check("f1_first_p01", {8'd0, obs_q[0].p01}, 32'h01);
      check("f1_first_p10", {8'd0, obs_q[0].p10}, 32'h10);
      check("f1_first_p11", {8'd0, obs_q[0].p11}, 32'h11);
      check("f1_first_xy", 32'(obs_q[0].x * 100 + obs_q[0].y), 32'd0);
      check("f1_last_p00", {8'd0, obs_q[5].p00}, 32'h12);
      check("f1_last_p01", {8'd0, obs_q[5].p01}, 32'h13);
      check("f1_last_p10", {8'd0, obs_q[5].p10}, 32'h22);
      check("f1_last_p11", {8'd0, obs_q[5].p11}, 32'h23);
      check("f1_last_eof", {31'd0, obs_q[5].eof}, 32'd1);
      n_eol = 0;
      foreach (obs_q[i]) if (obs_q[i].eol && obs_q[i].x == 2) n_eol++;
      check("f1_eol_count", 32'(n_eol), 32'd2);
    end

    // Random data with random gaps, several frames back to back
    clear_obs();
    for (int f = 0; f < 3; f++) begin
      frame_start();
      send_lines(V, 24'h0, 1'b1, 1'b1);
      frame_end(1'b0, '0);
    end
    check("gap_count", 32'(obs_q.size()), 32'd18);

    // Two extra lines past the frame height are ignored
    clear_obs();
    frame_start();
    send_lines(V + 2, 24'h300, 1'b0, 1'b0);
    frame_end(1'b0, '0);
    n_y2 = 0;
    foreach (obs_q[i]) if (obs_q[i].y == 2) n_y2++;
    check("extra_count", 32'(obs_q.size()), 32'd6);
    check("extra_no_y2", 32'(n_y2), 32'd0);
    check("extra_no_err", 32'(err_seen), 32'd0);

    // Frame ends after two pixels of the first line
    clear_obs();
    frame_start();
    drive_pix(24'hA00);
    drive_pix(24'hA01);
    frame_end(1'b0, '0);
    check("partial_err", 32'(err_seen), 32'd1);
    check("partial_nowin", 32'(obs_q.size()), 32'd0);
    clear_obs();
    frame_start();
    send_lines(V, 24'h500, 1'b0, 1'b0);
    frame_end(1'b0, '0);
    check("after_partial_count", 32'(obs_q.size()), 32'd6);

    // Pixels while no frame is active
    clear_obs();
    drive_pix(24'h55);
    idle(1);
    drive_pix(24'h66);
    idle(3);
    check("idle_pix_err", 32'(err_seen), 32'd2);
    check("idle_pix_nowin", 32'(obs_q.size()), 32'd0);

    // Falling edge coincident with the pixel that completes row 1
    clear_obs();
    frame_start();
    for (int c = 0; c < H; c++) drive_pix(pat(24'h700, 0, c));
    for (int c = 0; c < H - 1; c++) drive_pix(pat(24'h700, 1, c));
    frame_end(1'b1, pat(24'h700, 1, H - 1));
    check("fall_full_count", 32'(obs_q.size()), 32'd3);
    check("fall_full_noerr", 32'(err_seen), 32'd0);

    // Falling edge coincident with a pixel that leaves the line partial
    clear_obs();
    frame_start();
    drive_pix(24'h800);
    frame_end(1'b1, 24'h801);
    check("fall_part_err", 32'(err_seen), 32'd1);

    // Reset in the middle of row 1, then a fresh frame
    frame_start();
    for (int c = 0; c < H; c++) drive_pix(pat(24'h900, 0, c));
    drive_pix(pat(24'h900, 1, 0));
    drive_pix(pat(24'h900, 1, 1));
    do_reset();
    frame_start();
    send_lines(V, 24'h40, 1'b0, 1'b0);
    frame_end(1'b0, '0);
    check("rst_frame_count", 32'(obs_q.size()), 32'd6);
    if (obs_q.size() > 0) begin
      check("rst_first_xy", 32'(obs_q[0].x * 100 + obs_q[0].y), 32'd0);
      check("rst_first_p00", {8'd0, obs_q[0].p00}, 32'h40);
      check("rst_first_p11", {8'd0, obs_q[0].p11}, 32'h51);
    end

    idle(4);
    check("model_drained", 32'(exp_q.size() + err_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
